// File: rtl/instr_mem_loader.sv
// Instruction ROM writer: packs a valid/ready byte stream into little-endian 32-bit words
// and writes DEPTH words from address 0, holding the CPU until done. Optional: LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    localparam int unsigned CW = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            r_state,      w_state_nxt;
    logic              r_byte_ready, w_byte_ready_nxt;
    logic              r_mem_we,     w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nxt;
    logic [31:0]       r_mem_wdata,  w_mem_wdata_nxt;
    logic              r_cpu_hold,   w_cpu_hold_nxt;
    logic              r_busy,       w_busy_nxt;
    logic              r_done,       w_done_nxt;
    logic [CW-1:0]     r_word_count, w_word_count_nxt;
    logic [1:0]        r_idx,        w_idx_nxt;
    logic [23:0]       r_asm,        w_asm_nxt;
    logic              w_accept;
    logic              w_last;
    logic              w_enter;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]       r_checksum,   w_checksum_nxt;
`endif

    // Next-state and next-output logic; the top byte goes straight into the write data.
    always_comb begin
        w_state_nxt      = r_state;
        w_mem_we_nxt     = 1'b0;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_cpu_hold_nxt   = r_cpu_hold;
        w_busy_nxt       = r_busy;
        w_done_nxt       = r_done;
        w_word_count_nxt = r_word_count;
        w_idx_nxt        = r_idx;
        w_asm_nxt        = r_asm;
        w_enter          = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        w_checksum_nxt   = r_checksum;
`endif
        w_accept = byte_valid && r_byte_ready;
        w_last   = (r_word_count + CW'(1)) == CW'(DEPTH);

        case (r_state)
            S_IDLE: begin
                if (start) w_enter = 1'b1;
            end
            S_COLLECT: begin
                if (w_accept) begin
                    w_idx_nxt = r_idx + 2'd1;
                    case (r_idx)
                        2'd0: w_asm_nxt[7:0]   = byte_data;
                        2'd1: w_asm_nxt[15:8]  = byte_data;
                        2'd2: w_asm_nxt[23:16] = byte_data;
                        default: begin
                            w_mem_wdata_nxt = {byte_data, r_asm};
                            w_mem_we_nxt    = 1'b1;
                            w_state_nxt     = S_WRITE;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                w_mem_addr_nxt   = r_mem_addr + ADDR_W'(1);
                w_word_count_nxt = r_word_count + CW'(1);
`ifdef LOADER_CHECKSUM_EN
                w_checksum_nxt   = r_checksum ^ r_mem_wdata;
`endif
                if (w_last) begin
                    w_state_nxt    = S_DONE;
                    w_done_nxt     = 1'b1;
                    w_cpu_hold_nxt = 1'b0;
                    w_busy_nxt     = 1'b0;
                end else begin
                    w_state_nxt = S_COLLECT;
                end
            end
            default: begin
                if (start) w_enter = 1'b1;
            end
        endcase

        // Load entry, shared by first load and reload.
        if (w_enter) begin
            w_state_nxt      = S_COLLECT;
            w_mem_addr_nxt   = '0;
            w_word_count_nxt = '0;
            w_idx_nxt        = '0;
            w_done_nxt       = 1'b0;
            w_cpu_hold_nxt   = 1'b1;
            w_busy_nxt       = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            w_checksum_nxt   = '0;
`endif
        end

        w_byte_ready_nxt = (w_state_nxt == S_COLLECT);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_byte_ready <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_hold   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_word_count <= '0;
            r_idx        <= '0;
            r_asm        <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_checksum   <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_byte_ready <= w_byte_ready_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_cpu_hold   <= w_cpu_hold_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_word_count <= w_word_count_nxt;
            r_idx        <= w_idx_nxt;
            r_asm        <= w_asm_nxt;
`ifdef LOADER_CHECKSUM_EN
            r_checksum   <= w_checksum_nxt;
`endif
        end
    end

    assign byte_ready = r_byte_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_hold   = r_cpu_hold;
    assign busy       = r_busy;
    assign done       = r_done;
    assign word_count = r_word_count;
`ifdef LOADER_CHECKSUM_EN
    assign checksum   = r_checksum;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a DEPTH=13 instance and a DEPTH=1 instance.
// Checksum checks are compiled in with LOADER_CHECKSUM_EN.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start1;
    logic        byte_valid;
    logic [7:0]  byte_data;

    logic        ready, we, hold, busy, done;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [8:0]  wc;
    logic        ready1, we1, hold1, busy1, done1;
    logic [7:0]  addr1;
    logic [31:0] wdata1;
    logic [8:0]  wc1;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] cks, cks1;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0]  q_addr[$];
    logic [31:0] q_data[$];
    logic [7:0]  q1_addr[$];
    logic [31:0] q1_data[$];

    always #5 clk = ~clk;

    instr_mem_loader #(.ADDR_W(8), .DEPTH(13)) u_dut (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(ready), .mem_we(we), .mem_addr(addr), .mem_wdata(wdata),
        .cpu_hold(hold), .busy(busy), .done(done), .word_count(wc)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(cks)
`endif
    );

    instr_mem_loader #(.ADDR_W(8), .DEPTH(1)) u_one (
        .clk(clk), .rst(rst), .start(start1), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(ready1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
        .cpu_hold(hold1), .busy(busy1), .done(done1), .word_count(wc1)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(cks1)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write capture; sampled on the falling edge.
    always @(negedge clk) begin
        if (we) begin
            q_addr.push_back(addr);
            q_data.push_back(wdata);
            chk("ready_in_write", 64'(ready), 64'd0);
            chk("hold_in_write", 64'(hold), 64'd1);
        end
        if (we1) begin
            q1_addr.push_back(addr1);
            q1_data.push_back(wdata1);
        end
    end

    function automatic logic [7:0] pbyte(input int i);
        return 8'(32'h11 + 7 * i);
    endfunction

    function automatic logic [31:0] pword(input int w);
        return {pbyte(4*w+3), pbyte(4*w+2), pbyte(4*w+1), pbyte(4*w)};
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit sel, input int gap);
        int   n;
        logic r;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        r = sel ? ready1 : ready;
        while (!r && n < 40) begin
            @(negedge clk);
            n++;
            r = sel ? ready1 : ready;
        end
        if (!r) chk("accept_timeout", 64'(r), 64'd1);
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    task automatic pulse_start(input bit sel);
        @(negedge clk);
        if (sel) start1 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", 64'(done), 64'd1);
    endtask

    // Full 13-word load; optional random gaps and start pokes while busy.
    task automatic load(input int gapmax, input bit poke);
        for (int w = 0; w < 13; w++) begin
            if (poke && w == 6) begin
                pulse_start(1'b0);
                chk("poke1_wc", 64'(wc), 64'd6);
                chk("poke1_addr", 64'(addr), 64'd6);
                pulse_start(1'b0);
                chk("poke2_wc", 64'(wc), 64'd6);
                chk("poke2_addr", 64'(addr), 64'd6);
                chk("poke2_busy", 64'(busy), 64'd1);
            end
            for (int k = 0; k < 4; k++)
                send_byte(pbyte(4*w+k), 1'b0, (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
        end
        wait_done();
    endtask

    task automatic check_load();
        chk("wr_count", 64'(q_addr.size()), 64'd13);
        for (int i = 0; i < q_addr.size() && i < 13; i++) begin
            chk($sformatf("wr_addr%0d", i), 64'(q_addr[i]), 64'(i));
            chk($sformatf("wr_data%0d", i), 64'(q_data[i]), 64'(pword(i)));
        end
        chk("end_hold", 64'(hold), 64'd0);
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_ready", 64'(ready), 64'd0);
        chk("end_wc", 64'(wc), 64'd13);
        chk("end_addr", 64'(addr), 64'd13);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; start1 = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;

        // Reset state, then idle after release
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_hold", 64'(hold), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ready", 64'(ready), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_hold", 64'(hold), 64'd0);
        chk("idle_wc", 64'(wc), 64'd0);

        // Single-word load, DEPTH=1
        pulse_start(1'b1);
        chk("one_hold", 64'(hold1), 64'd1);
        send_byte(8'h40, 1'b1, 0);
        send_byte(8'h10, 1'b1, 0);
        send_byte(8'h03, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        @(negedge clk);
        chk("one_we", 64'(we1), 64'd1);
        chk("one_addr", 64'(addr1), 64'd0);
        chk("one_wdata", 64'(wdata1), 64'h00031040);
        @(negedge clk);
        chk("one_done", 64'(done1), 64'd1);
        chk("one_hold_rel", 64'(hold1), 64'd0);
        chk("one_wc", 64'(wc1), 64'd1);
        chk("one_wr_count", 64'(q1_addr.size()), 64'd1);

        // Full gap-free load
        q_addr.delete(); q_data.delete();
        pulse_start(1'b0);
        chk("load_hold", 64'(hold), 64'd1);
        chk("load_busy", 64'(busy), 64'd1);
        load(0, 1'b0);
        check_load();
`ifdef LOADER_CHECKSUM_EN
        begin
            logic [31:0] x = '0;
            for (int i = 0; i < 13; i++) x ^= pword(i);
            chk("cks_full", 64'(cks), 64'(x));
        end
`endif

        // Reload from DONE with gaps and ignored start pulses
        q_addr.delete(); q_data.delete();
        pulse_start(1'b0);
        chk("reload_done_clr", 64'(done), 64'd0);
        load(3, 1'b1);
        check_load();

        // Abort mid-word, then restart
        q_addr.delete(); q_data.delete();
        pulse_start(1'b0);
        for (int i = 0; i < 14; i++) send_byte(pbyte(i), 1'b0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hold", 64'(hold), 64'd0);
        chk("abort_ready", 64'(ready), 64'd0);
        chk("abort_addr", 64'(addr), 64'd0);
        chk("abort_wc", 64'(wc), 64'd0);
        chk("abort_wdata", 64'(wdata), 64'd0);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_wr_count", 64'(q_addr.size()), 64'd3);
        chk("abort_we", 64'(we), 64'd0);
        q_addr.delete(); q_data.delete();
        pulse_start(1'b0);
        load(0, 1'b0);
        check_load();

`ifdef LOADER_CHECKSUM_EN
        // Checksum of words 0x1 and 0x3
        pulse_start(1'b0);
        chk("cks_clear", 64'(cks), 64'd0);
        send_byte(8'h01, 1'b0, 0); send_byte(8'h00, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0); send_byte(8'h00, 1'b0, 0);
        send_byte(8'h03, 1'b0, 0); send_byte(8'h00, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0); send_byte(8'h00, 1'b0, 0);
        repeat (2) @(negedge clk);
        chk("cks_two", 64'(cks), 64'h2);
        chk("cks_wc", 64'(wc), 64'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
